// File: rtl/secuenciador_memoria_corte.sv
// Sequencer that owns the 512x12 cut-program RAM: LOAD writes host words from address 0,
// RUN reads them back from 0 and streams them to the cutter over a valid/listo handshake.
module secuenciador_memoria_corte #(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0] END_MARK   = 12'hFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cargar,
    input  logic                  iniciar,
    input  logic                  abortar,
    input  logic [DATA_WIDTH-1:0] dato_carga,
    input  logic                  dato_carga_valido,
    output logic                  carga_listo,
    output logic [DATA_WIDTH-1:0] dato_salida,
    output logic                  dato_salida_valido,
    input  logic                  dato_salida_listo,
    output logic                  ocupado,
    output logic                  corte_terminado,
    output logic                  error_lleno,
    output logic                  leer_escribir_memoria,
    output logic [ADDR_WIDTH-1:0] direccion_memoria,
    output logic [DATA_WIDTH-1:0] dato_escribir_memoria,
    input  logic [DATA_WIDTH-1:0] dato_leer_memoria
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RD_ADDR,
        RD_CHECK,
        PRESENT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   wr_ptr_next;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr_next;
    logic [DATA_WIDTH-1:0]   salida_reg;
    logic [DATA_WIDTH-1:0]   salida_next;
    logic                    error_reg;
    logic                    error_next;
    logic                    abort_active;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            salida_reg <= '0;
            error_reg  <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            rd_ptr     <= rd_ptr_next;
            salida_reg <= salida_next;
            error_reg  <= error_next;
        end
    end

    assign abort_active = abortar && (state != IDLE);

    // Abort beats every other same-cycle event: no write, no pulse, pointers and flags frozen.
    always_comb begin
        state_next            = state;
        wr_ptr_next           = wr_ptr;
        rd_ptr_next           = rd_ptr;
        salida_next           = salida_reg;
        error_next            = error_reg;
        carga_listo           = 1'b0;
        corte_terminado       = 1'b0;
        leer_escribir_memoria = 1'b0;
        dato_escribir_memoria = '0;
        direccion_memoria     = (state == LOAD) ? wr_ptr : rd_ptr;
        dato_salida_valido    = (state == PRESENT);

        if (abort_active) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cargar) begin
                        state_next  = LOAD;
                        wr_ptr_next = '0;
                        error_next  = 1'b0;
                    end else if (iniciar) begin
                        state_next  = RD_ADDR;
                        rd_ptr_next = '0;
                    end
                end
                LOAD: begin
                    carga_listo = 1'b1;
                    if (dato_carga_valido) begin
                        leer_escribir_memoria = 1'b1;
                        // The last cell always ends up holding the end mark so a RUN can never overrun.
                        if (wr_ptr == LAST_ADDR && dato_carga != END_MARK) begin
                            dato_escribir_memoria = END_MARK;
                            error_next            = 1'b1;
                            state_next            = IDLE;
                        end else begin
                            dato_escribir_memoria = dato_carga;
                            if (dato_carga == END_MARK || wr_ptr == LAST_ADDR) begin
                                state_next = IDLE;
                            end
                        end
                        if (wr_ptr != LAST_ADDR) begin
                            wr_ptr_next = wr_ptr + 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    state_next = RD_CHECK;
                end
                RD_CHECK: begin
                    if (dato_leer_memoria == END_MARK) begin
                        corte_terminado = 1'b1;
                        state_next      = IDLE;
                    end else begin
                        salida_next = dato_leer_memoria;
                        state_next  = PRESENT;
                    end
                end
                PRESENT: begin
                    if (dato_salida_listo) begin
                        if (rd_ptr == LAST_ADDR) begin
                            corte_terminado = 1'b1;
                            state_next      = IDLE;
                        end else begin
                            rd_ptr_next = rd_ptr + 1'b1;
                            state_next  = RD_ADDR;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign ocupado     = (state != IDLE);
    assign dato_salida = salida_reg;
    assign error_lleno = error_reg;

endmodule
